risc_pipe_core: RTL

// Parametrised 3-stage integer core (ID -> EX -> WB) with a streaming instruction input.

---
 rtl/risc_pipe_core.sv | 134 +++++++++++++
 1 files changed

// File: rtl/risc_pipe_core.sv
// risc_pipe_core: 3-stage ID/EX/WB integer core with streaming instruction input,
// full EX/WB forwarding, multi-cycle MUL stall and optional hardwired-zero r0.
module risc_pipe_core #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int INST_W     = 32,
    parameter int MUL_CYC    = 2,
    parameter int R0_ZERO    = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  INST_VALID,
    input  logic [INST_W-1:0]     INST,
    output logic                  INST_READY,
    input  logic                  DBG_WE,
    input  logic [REG_ADDR_W-1:0] DBG_WADDR,
    input  logic [DATA_W-1:0]     DBG_WDATA,
    input  logic [REG_ADDR_W-1:0] DBG_RADDR,
    output logic [DATA_W-1:0]     DBG_RDATA,
    output logic                  WB_VALID,
    output logic [REG_ADDR_W-1:0] WB_ADDR,
    output logic [DATA_W-1:0]     WB_DATA,
    output logic                  BUSY
);
    localparam int RN = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0]     rf [RN];
    logic                  id_v, id_nop;
    logic [3:0]            id_opc;
    logic [REG_ADDR_W-1:0] id_ra, id_rb, id_rd;
    logic                  ex_v, ex_wen;
    logic [3:0]            ex_opc;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_a, ex_b, ex_res;
    logic [1:0]            ex_cnt;
    logic                  wb_v, wb_wen;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_d, fwd_a, fwd_b;
    logic                  stall;

    // EX is only ever forwarded from on non-stall edges, so its result is final there.
    function automatic logic [DATA_W-1:0] operand(input logic [REG_ADDR_W-1:0] r);
        return (R0_ZERO != 0 && r == '0) ? '0 :
               (ex_v && ex_wen && ex_rd == r) ? ex_res :
               (wb_v && wb_wen && wb_rd == r) ? wb_d : rf[r];
    endfunction

    assign fwd_a      = operand(id_ra);
    assign fwd_b      = operand(id_rb);
    assign stall      = ex_v && ex_wen && ex_opc == 4'd1 && ex_cnt < 2'(MUL_CYC - 1);
    assign INST_READY = ~stall;
    assign WB_VALID   = wb_v && wb_wen;
    assign WB_ADDR    = wb_rd;
    assign WB_DATA    = wb_d;
    assign BUSY       = id_v | ex_v | wb_v;
    assign DBG_RDATA  = rf[DBG_RADDR];

    always_comb begin
        ex_res = '0;
        case (ex_opc)
            4'd0: ex_res = ex_a + ex_b;
            4'd1: ex_res = ex_a * ex_b;
            4'd2: ex_res = ex_b << ex_a[4:0];
            4'd3: ex_res = ex_a ^ ex_b;
            4'd4: ex_res = ~(ex_a | ex_b);
            4'd5: ex_res = ex_a - ex_b;
            4'd6: ex_res = ex_a & ex_b;
            4'd7: ex_res = ex_a | ex_b;
            4'd8: ex_res = ex_b >> ex_a[4:0];
            4'd9: ex_res = $signed(ex_b) >>> ex_a[4:0];
            default: ex_res = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            id_v   <= 1'b0;
            id_nop <= 1'b0;
            id_opc <= '0;
            id_ra  <= '0;
            id_rb  <= '0;
            id_rd  <= '0;
            ex_v   <= 1'b0;
            ex_wen <= 1'b0;
            ex_opc <= '0;
            ex_rd  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            ex_cnt <= '0;
            wb_v   <= 1'b0;
            wb_wen <= 1'b0;
            wb_rd  <= '0;
            wb_d   <= '0;
        end else if (stall) begin
            wb_v   <= 1'b0;
            ex_cnt <= ex_cnt + 2'd1;
        end else begin
            wb_v   <= ex_v;
            wb_wen <= ex_v && ex_wen;
            if (ex_v) begin
                wb_rd <= ex_rd;
                wb_d  <= ex_res;
            end
            ex_v   <= id_v;
            ex_wen <= id_v && !id_nop;
            ex_opc <= id_opc;
            ex_rd  <= id_rd;
            ex_a   <= fwd_a;
            ex_b   <= fwd_b;
            ex_cnt <= '0;
            id_v   <= INST_VALID;
            if (INST_VALID) begin
                id_nop <= INST[31] || INST[18:15] > 4'd9;
                id_opc <= INST[18:15];
                id_ra  <= INST[0 +: REG_ADDR_W];
                id_rb  <= INST[5 +: REG_ADDR_W];
                id_rd  <= INST[10 +: REG_ADDR_W];
            end
        end
    end

    // WB has priority over a debug write to the same register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < RN; i++) rf[i] <= '0;
        end else if (wb_v && wb_wen && !(R0_ZERO != 0 && wb_rd == '0)) begin
            rf[wb_rd] <= wb_d;
            if (DBG_WE && DBG_WADDR != wb_rd && !(R0_ZERO != 0 && DBG_WADDR == '0))
                rf[DBG_WADDR] <= DBG_WDATA;
        end else if (DBG_WE && !(R0_ZERO != 0 && DBG_WADDR == '0)) begin
            rf[DBG_WADDR] <= DBG_WDATA;
        end
    end
endmodule
